sprite_mover: RTL

Parametrised sprite position/direction controller for the VGA game layer (Pac-Man, ghosts).
- Accepts direction commands from the on-board keypad and the PS/2 keyboard, with an independent edge detector per source.
- Steps the sprite on a grid with clamped bounds. Supports manual stepping and an auto-run mode driven by a tick.
- Generates the rotated sprite-ROM address for the current pixel, with hit and address registered.
- One instance per sprite, between the input decoders and the VGA pixel mux.

---
 rtl/sprite_pkg.sv | 60 ++++++
 rtl/sprite_addr_gen.sv | 69 ++++++
 rtl/sprite_mover.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared direction encoding and input-code decode for sprite movers
//
// Purpose: direction type, keypad / PS/2 make-code constants and the
// command decoders used by sprite_mover and sprite_addr_gen.
// Ports: none (package).

package sprite_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    localparam logic [4:0] KEY_UP    = 5'h09;
    localparam logic [4:0] KEY_DOWN  = 5'h11;
    localparam logic [4:0] KEY_LEFT  = 5'h0C;
    localparam logic [4:0] KEY_RIGHT = 5'h0E;

    localparam logic [7:0] PS2_UP    = 8'h75;
    localparam logic [7:0] PS2_DOWN  = 8'h72;
    localparam logic [7:0] PS2_LEFT  = 8'h6B;
    localparam logic [7:0] PS2_RIGHT = 8'h74;

    typedef struct packed {
        logic valid;
        dir_t dir;
    } cmd_t;

    function automatic cmd_t decode_key(input logic [4:0] code);
        cmd_t c;
        c.valid = 1'b1;
        c.dir   = DIR_UP;
        case (code)
            KEY_UP:    c.dir = DIR_UP;
            KEY_DOWN:  c.dir = DIR_DOWN;
            KEY_LEFT:  c.dir = DIR_LEFT;
            KEY_RIGHT: c.dir = DIR_RIGHT;
            default:   c.valid = 1'b0;
        endcase
        return c;
    endfunction

    // release_flag set means a key-up event, which never moves the sprite
    function automatic cmd_t decode_ps2(input logic [7:0] code, input logic release_flag);
        cmd_t c;
        c.valid = !release_flag;
        c.dir   = DIR_UP;
        case (code)
            PS2_UP:    c.dir = DIR_UP;
            PS2_DOWN:  c.dir = DIR_DOWN;
            PS2_LEFT:  c.dir = DIR_LEFT;
            PS2_RIGHT: c.dir = DIR_RIGHT;
            default:   c.valid = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// rtl/sprite_addr_gen.sv - registered sprite hit test and rotated sprite-ROM address
//
// Purpose: decides whether the current VGA pixel lies inside the sprite and
// produces the ROM address rotated according to the facing direction.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   row_addr, col_addr  current VGA pixel
//   pos_x, pos_y        sprite top-left corner
//   dir                 facing direction (dir_t encoding)
//   hit                 registered in-sprite flag
//   rom_addr            registered rotated ROM address (holds when outside)

module sprite_addr_gen
    import sprite_pkg::*;
#(
    parameter int X_W      = 10,
    parameter int Y_W      = 9,
    parameter int SPR_LOG2 = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [Y_W-1:0]        row_addr,
    input  logic [X_W-1:0]        col_addr,
    input  logic [X_W-1:0]        pos_x,
    input  logic [Y_W-1:0]        pos_y,
    input  logic [1:0]            dir,
    output logic                  hit,
    output logic [2*SPR_LOG2-1:0] rom_addr
);

    localparam logic [X_W:0] SPR_X = (X_W+1)'(1 << SPR_LOG2);
    localparam logic [Y_W:0] SPR_Y = (Y_W+1)'(1 << SPR_LOG2);

    logic [X_W:0]            dx_e;
    logic [Y_W:0]            dy_e;
    logic [SPR_LOG2-1:0]     dx;
    logic [SPR_LOG2-1:0]     dy;
    logic                    in_spr;
    logic [2*SPR_LOG2-1:0]   addr_c;

    always_comb begin
        // One extra bit catches pixels left of / above the sprite as a borrow
        dx_e   = {1'b0, col_addr} - {1'b0, pos_x};
        dy_e   = {1'b0, row_addr} - {1'b0, pos_y};
        in_spr = !dx_e[X_W] && (dx_e < SPR_X) && !dy_e[Y_W] && (dy_e < SPR_Y);
        dx     = dx_e[SPR_LOG2-1:0];
        dy     = dy_e[SPR_LOG2-1:0];
        // S-1-v is the bitwise inverse of v within SPR_LOG2 bits
        case (dir)
            DIR_UP:    addr_c = {dx, dy};
            DIR_DOWN:  addr_c = {dx, ~dy};
            DIR_LEFT:  addr_c = {dy, dx};
            default:   addr_c = {dy, ~dx};
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit      <= 1'b0;
            rom_addr <= '0;
        end else begin
            hit <= in_spr;
            if (in_spr) begin
                rom_addr <= addr_c;
            end
        end
    end

endmodule

// File: rtl/sprite_mover.sv
// rtl/sprite_mover.sv - sprite position/direction controller with clamped grid stepping
//
// Purpose: edge-detects keypad and PS/2 direction commands, steps the sprite
// manually or on move_tick in auto mode, and drives the pixel hit/ROM address.
// Optional macro SPRITE_MOVER_WRAP_EN: X axis wraps (tunnel) instead of clamping.
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   key_code, key_ready    keypad command and its level valid
//   ps2_data, ps2_ready    PS/2 scan data ([7:0] code, [8] release) and level valid
//   auto_en, move_tick     auto-run select and its step pulse
//   row_addr, col_addr     current VGA pixel
//   pos_x, pos_y, dir      sprite state
//   moved, blocked         one-cycle step result pulses
//   hit, rom_addr          registered pixel outputs

module sprite_mover
    import sprite_pkg::*;
#(
    parameter int X_W      = 10,
    parameter int Y_W      = 9,
    parameter int SPR_LOG2 = 5,
    parameter int STEP     = 32,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 608,
    parameter int Y_MIN    = 0,
    parameter int Y_MAX    = 448,
    parameter int X_INIT   = 320,
    parameter int Y_INIT   = 240
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            key_code,
    input  logic                  key_ready,
    input  logic [9:0]            ps2_data,
    input  logic                  ps2_ready,
    input  logic                  auto_en,
    input  logic                  move_tick,
    input  logic [Y_W-1:0]        row_addr,
    input  logic [X_W-1:0]        col_addr,
    output logic [X_W-1:0]        pos_x,
    output logic [Y_W-1:0]        pos_y,
    output logic [1:0]            dir,
    output logic                  moved,
    output logic                  blocked,
    output logic                  hit,
    output logic [2*SPR_LOG2-1:0] rom_addr
);

    localparam logic [X_W:0]   XMIN_E  = (X_W+1)'(X_MIN);
    localparam logic [X_W:0]   XMAX_E  = (X_W+1)'(X_MAX);
    localparam logic [X_W:0]   XSTEP_E = (X_W+1)'(STEP);
    localparam logic [Y_W:0]   YMIN_E  = (Y_W+1)'(Y_MIN);
    localparam logic [Y_W:0]   YMAX_E  = (Y_W+1)'(Y_MAX);
    localparam logic [Y_W:0]   YSTEP_E = (Y_W+1)'(STEP);
    localparam logic [X_W-1:0] XMIN_N  = X_W'(X_MIN);
    localparam logic [X_W-1:0] XMAX_N  = X_W'(X_MAX);
    localparam logic [Y_W-1:0] YMIN_N  = Y_W'(Y_MIN);
    localparam logic [Y_W-1:0] YMAX_N  = Y_W'(Y_MAX);

    logic     key_prev;
    logic     ps2_prev;
    // Clear for the first cycle after reset so that ready levels already
    // high at release are captured into the edge registers without firing.
    logic     armed;
    dir_t     dir_q;

    logic     key_fire;
    logic     ps2_fire;
    cmd_t     key_cmd;
    cmd_t     ps2_cmd;
    logic     cmd_valid;
    dir_t     cmd_dir;
    dir_t     step_dir;
    logic     do_step;
    logic     ps2_unused;

    logic [X_W:0]   x_dec_e;
    logic [X_W:0]   x_inc_e;
    logic [Y_W:0]   y_dec_e;
    logic [Y_W:0]   y_inc_e;
    logic           x_under;
    logic           x_over;
    logic           y_under;
    logic           y_over;
    logic [X_W-1:0] nx;
    logic [Y_W-1:0] ny;
    logic           wrapped;

    // Bit 9 of the PS/2 word carries nothing for this block
    assign ps2_unused = ps2_data[9];

    assign key_fire = armed && key_ready && !key_prev;
    assign ps2_fire = armed && ps2_ready && !ps2_prev;
    assign key_cmd  = decode_key(key_code);
    assign ps2_cmd  = decode_ps2(ps2_data[7:0], ps2_data[8]);

    always_comb begin
        cmd_valid = 1'b0;
        cmd_dir   = DIR_UP;
        // PS/2 takes precedence; a keypad command in the same cycle is dropped
        if (ps2_fire && ps2_cmd.valid) begin
            cmd_valid = 1'b1;
            cmd_dir   = ps2_cmd.dir;
        end else if (key_fire && key_cmd.valid) begin
            cmd_valid = 1'b1;
            cmd_dir   = key_cmd.dir;
        end
        step_dir = cmd_valid ? cmd_dir : dir_q;
        do_step  = auto_en ? move_tick : cmd_valid;
    end

    always_comb begin
        x_dec_e = {1'b0, pos_x} - XSTEP_E;
        x_inc_e = {1'b0, pos_x} + XSTEP_E;
        y_dec_e = {1'b0, pos_y} - YSTEP_E;
        y_inc_e = {1'b0, pos_y} + YSTEP_E;
        // A borrow or a result under MIN both mean pos < MIN+STEP
        x_under = x_dec_e[X_W] || (x_dec_e < XMIN_E);
        x_over  = x_inc_e > XMAX_E;
        y_under = y_dec_e[Y_W] || (y_dec_e < YMIN_E);
        y_over  = y_inc_e > YMAX_E;

        nx      = pos_x;
        ny      = pos_y;
        wrapped = 1'b0;
        case (step_dir)
            DIR_UP:   ny = y_under ? YMIN_N : y_dec_e[Y_W-1:0];
            DIR_DOWN: ny = y_over  ? YMAX_N : y_inc_e[Y_W-1:0];
`ifdef SPRITE_MOVER_WRAP_EN
            DIR_LEFT: begin
                nx      = x_under ? XMAX_N : x_dec_e[X_W-1:0];
                wrapped = x_under;
            end
            default: begin
                nx      = x_over ? XMIN_N : x_inc_e[X_W-1:0];
                wrapped = x_over;
            end
`else
            DIR_LEFT: nx = x_under ? XMIN_N : x_dec_e[X_W-1:0];
            default:  nx = x_over  ? XMAX_N : x_inc_e[X_W-1:0];
`endif
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_prev <= 1'b0;
            ps2_prev <= 1'b0;
            armed    <= 1'b0;
            pos_x    <= X_W'(X_INIT);
            pos_y    <= Y_W'(Y_INIT);
            dir_q    <= DIR_UP;
            moved    <= 1'b0;
            blocked  <= 1'b0;
        end else begin
            key_prev <= key_ready;
            ps2_prev <= ps2_ready;
            armed    <= 1'b1;
            moved    <= 1'b0;
            blocked  <= 1'b0;
            if (cmd_valid) begin
                dir_q <= cmd_dir;
            end
            if (do_step) begin
                pos_x <= nx;
                pos_y <= ny;
                if (nx != pos_x || ny != pos_y || wrapped) begin
                    moved <= 1'b1;
                end else begin
                    blocked <= 1'b1;
                end
            end
        end
    end

    assign dir = dir_q;

    sprite_addr_gen #(
        .X_W      (X_W),
        .Y_W      (Y_W),
        .SPR_LOG2 (SPR_LOG2)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .row_addr (row_addr),
        .col_addr (col_addr),
        .pos_x    (pos_x),
        .pos_y    (pos_y),
        .dir      (dir_q),
        .hit      (hit),
        .rom_addr (rom_addr)
    );

endmodule
